// File: rtl/capture_seq.sv
// Capture sequencer: arm, pre-trigger fill, post-trigger delay over one or more
// segments, then a word-by-word readback handshake with the output sender.
module capture_seq #(
   parameter int DW  = 32,
   parameter int CW  = 18,
   parameter int SGW = 4
) (
   input  logic           sys_clk,
   input  logic           sys_rst,
   input  logic [31:0]    cfg_data,
   input  logic           wr_read,
   input  logic           wr_delay,
   input  logic           wr_segs,
   input  logic           arm,
   input  logic           run,
   input  logic           finish_now,
   input  logic           sti_valid,
   input  logic [DW-1:0]  sti_data,
   input  logic           out_busy,
   output logic           mem_wr,
   output logic [DW-1:0]  mem_wr_data,
   output logic           mem_last,
   output logic           mem_rd,
   output logic           out_send,
   output logic [SGW-1:0] seg_idx,
   output logic           armed,
   output logic           done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SAMPLE,
      S_DELAY,
      S_READ,
      S_SEND,
      S_WAIT
   } state_t;

   state_t         state, state_nx;

   logic [CW-1:0]  read_cnt, delay_cnt;
   logic [SGW-1:0] seg_cnt;
   logic [CW-1:0]  read_act, delay_act;
   logic [SGW-1:0] seg_act;

   logic [CW-1:0]  dly_ctr, dly_ctr_nx;
   logic [CW-1:0]  rd_ctr, rd_ctr_nx;
   logic [SGW-1:0] seg_idx_nx;
   logic           wait_first, wait_first_nx;
   logic           load_act, seg_end, abort;
   logic           wr_nx, last_nx, rd_nx, send_nx, done_nx;

   // Only the low bits of the shared command bus are meaningful here.
   logic           cfg_unused;
   assign cfg_unused = ^cfg_data;

   assign armed = (state == S_SAMPLE) || (state == S_DELAY);

   // Config writes land in shadow registers; they are copied into the active set on arm.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         read_cnt  <= '0;
         delay_cnt <= '0;
         seg_cnt   <= '0;
      end else begin
         if (wr_read)  read_cnt  <= cfg_data[CW-1:0];
         if (wr_delay) delay_cnt <= cfg_data[CW-1:0];
         if (wr_segs)  seg_cnt   <= cfg_data[SGW-1:0];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state       <= S_IDLE;
         read_act    <= '0;
         delay_act   <= '0;
         seg_act     <= '0;
         dly_ctr     <= '0;
         rd_ctr      <= '0;
         seg_idx     <= '0;
         wait_first  <= 1'b0;
         mem_wr      <= 1'b0;
         // NOTE: the data register is reset (not left free-running) so every output reads 0 in reset.
         mem_wr_data <= '0;
         mem_last    <= 1'b0;
         mem_rd      <= 1'b0;
         out_send    <= 1'b0;
         done        <= 1'b0;
      end else begin
         state      <= state_nx;
         if (load_act) begin
            read_act  <= read_cnt;
            delay_act <= delay_cnt;
            seg_act   <= seg_cnt;
         end
         dly_ctr    <= dly_ctr_nx;
         rd_ctr     <= rd_ctr_nx;
         seg_idx    <= seg_idx_nx;
         wait_first <= wait_first_nx;
         mem_wr     <= wr_nx;
         if (wr_nx) mem_wr_data <= sti_data;
         mem_last   <= last_nx;
         mem_rd     <= rd_nx;
         out_send   <= send_nx;
         done       <= done_nx;
      end
   end

   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      state_nx      = state;
      dly_ctr_nx    = dly_ctr;
      rd_ctr_nx     = rd_ctr;
      seg_idx_nx    = seg_idx;
      wait_first_nx = 1'b0;
      load_act      = 1'b0;
      seg_end       = 1'b0;
      abort         = 1'b0;
      wr_nx         = 1'b0;
      last_nx       = 1'b0;
      rd_nx         = 1'b0;
      send_nx       = 1'b0;
      done_nx       = 1'b0;

      case (state)
         S_IDLE: begin
            if (arm) begin
               state_nx   = S_SAMPLE;
               seg_idx_nx = '0;
               load_act   = 1'b1;
            end
         end
         S_SAMPLE: begin
            if (finish_now) begin
               abort = 1'b1;
            end else begin
               wr_nx = sti_valid;
               // A valid run-cycle sample is post-trigger sample 0.
               if (run) begin
                  if (sti_valid && (delay_act == '0)) begin
                     seg_end = 1'b1;
                  end else begin
                     state_nx   = S_DELAY;
                     dly_ctr_nx = sti_valid ? CW'(1) : '0;
                  end
               end
            end
         end
         S_DELAY: begin
            if (finish_now) begin
               abort = 1'b1;
            end else if (sti_valid) begin
               wr_nx = 1'b1;
               if (dly_ctr == delay_act) seg_end = 1'b1;
               else                      dly_ctr_nx = dly_ctr + 1'b1;
            end
         end
         S_READ: begin
            rd_nx    = 1'b1;
            state_nx = S_SEND;
         end
         S_SEND: begin
            send_nx       = 1'b1;
            wait_first_nx = 1'b1;
            state_nx      = S_WAIT;
         end
         S_WAIT: begin
            // The sender only sees out_send during the first WAIT cycle, so busy is meaningless there.
            if (!wait_first && !out_busy) begin
               if (rd_ctr == read_act) begin
                  done_nx  = 1'b1;
                  state_nx = S_IDLE;
               end else begin
                  rd_ctr_nx = rd_ctr + 1'b1;
                  state_nx  = S_READ;
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase

      if (seg_end) begin
         if (seg_idx < seg_act) begin
            seg_idx_nx = seg_idx + 1'b1;
            state_nx   = S_SAMPLE;
         end else begin
            last_nx   = 1'b1;
            rd_ctr_nx = '0;
            state_nx  = S_READ;
         end
      end

      // Abort leaves a marker-only mem_last; the finish_now-cycle sample is not written.
      if (abort) begin
         last_nx   = 1'b1;
         rd_ctr_nx = '0;
         state_nx  = S_READ;
      end
   end

endmodule

// File: tb/tb_capture_seq.sv
// Self-checking bench for capture_seq: directed scenarios plus randomized captures
// compared against a sample-level reference model.
module tb_capture_seq;

   localparam int DW   = 32;
   localparam int CW   = 10;
   localparam int SGW  = 4;
   localparam int DMAX = (1 << CW) - 1;

   logic           sys_clk = 1'b0;
   logic           sys_rst = 1'b1;
   logic [31:0]    cfg_data = '0;
   logic           wr_read = 1'b0, wr_delay = 1'b0, wr_segs = 1'b0;
   logic           arm = 1'b0, run = 1'b0, finish_now = 1'b0;
   logic           sti_valid = 1'b0;
   logic [DW-1:0]  sti_data = '0;
   logic           out_busy = 1'b0;
   logic           mem_wr, mem_last, mem_rd, out_send, armed, done;
   logic [DW-1:0]  mem_wr_data;
   logic [SGW-1:0] seg_idx;

   capture_seq #(.DW(DW), .CW(CW), .SGW(SGW)) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .cfg_data    (cfg_data),
      .wr_read     (wr_read),
      .wr_delay    (wr_delay),
      .wr_segs     (wr_segs),
      .arm         (arm),
      .run         (run),
      .finish_now  (finish_now),
      .sti_valid   (sti_valid),
      .sti_data    (sti_data),
      .out_busy    (out_busy),
      .mem_wr      (mem_wr),
      .mem_wr_data (mem_wr_data),
      .mem_last    (mem_last),
      .mem_rd      (mem_rd),
      .out_send    (out_send),
      .seg_idx     (seg_idx),
      .armed       (armed),
      .done        (done)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      bit            v;
      logic [DW-1:0] d;
      bit            run;
      bit            fin;
   } stim_t;

   stim_t        stim[$];
   logic [DW:0]  got_wr[$], exp_wr[$];
   int           send_cyc[$];
   int           n_cmp = 0, n_err = 0;
   int           cyc = 0, n_marker, n_rd, n_send, n_done, n_clash, n_rd_busy;
   int           seg_steps, seg_max, armed_at_last;
   logic [SGW-1:0] prev_seg;
   int           busy_mode = 0, busy_left = 0;
   bit           inject_arm = 1'b0;
   int           cfg_rd = 0, cfg_dl = 0, cfg_sg = 0;
   int           exp_marker, exp_seg;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock: sample outputs 1 time unit after the edge, then update responsive inputs.
   task automatic tick();
      @(posedge sys_clk);
      #1;
      cyc++;
      if (mem_wr) got_wr.push_back({mem_last, mem_wr_data});
      if (mem_last && !mem_wr) n_marker++;
      if (mem_last && armed) armed_at_last++;
      if (mem_rd) n_rd++;
      if (mem_rd && mem_wr) n_clash++;
      if (busy_mode == 1 && mem_rd && out_busy) n_rd_busy++;
      if (out_send) begin
         n_send++;
         send_cyc.push_back(cyc);
      end
      if (done) n_done++;
      if (seg_idx != prev_seg) begin
         seg_steps++;
         prev_seg = seg_idx;
      end
      if (int'(seg_idx) > seg_max) seg_max = int'(seg_idx);
      arm = inject_arm && mem_last;
      if (arm) inject_arm = 1'b0;
      if (busy_mode == 1) begin
         if (out_send) busy_left = 20;
         out_busy = (busy_left > 0);
         if (busy_left > 0) busy_left--;
      end else if (busy_mode == 2) begin
         out_busy = ($urandom % 3) == 0;
      end else begin
         out_busy = 1'b0;
      end
   endtask

   task automatic clr();
      got_wr.delete();
      send_cyc.delete();
      n_marker = 0; n_rd = 0; n_send = 0; n_done = 0; n_clash = 0; n_rd_busy = 0;
      seg_steps = 0; armed_at_last = 0;
      prev_seg = seg_idx;
      seg_max  = int'(seg_idx);
   endtask

   task automatic write_cfg(input int rd, input int dl, input int sg);
      cfg_data = 32'(rd); wr_read  = 1'b1; tick(); wr_read  = 1'b0;
      cfg_data = 32'(dl); wr_delay = 1'b1; tick(); wr_delay = 1'b0;
      cfg_data = 32'(sg); wr_segs  = 1'b1; tick(); wr_segs  = 1'b0;
      cfg_rd = rd; cfg_dl = dl; cfg_sg = sg;
   endtask

   task automatic push(input bit v, input logic [DW-1:0] d, input bit r, input bit f);
      stim.push_back('{v, d, r, f});
   endtask

   // Walk the sample stream: pre-trigger until run, then count delay+1 post-trigger
   // samples per segment; finish_now ends everything with a marker and no write.
   task automatic model(input int dl, input int sg);
      int seg, post;
      bit cap, sd, lst;
      seg = 0; post = -1; cap = 1'b1;
      exp_wr.delete();
      exp_marker = 0;
      foreach (stim[i]) begin
         if (!cap) break;
         if (stim[i].fin) begin
            exp_marker = 1;
            cap = 1'b0;
         end else begin
            if (post < 0 && stim[i].run) post = 0;
            if (stim[i].v) begin
               sd  = (post >= 0) && (post == dl);
               lst = sd && (seg == sg);
               exp_wr.push_back({lst, stim[i].d});
               if (sd) begin
                  if (lst) cap = 1'b0;
                  else begin
                     seg++;
                     post = -1;
                  end
               end else if (post >= 0) begin
                  post++;
               end
            end
         end
      end
      exp_seg = seg;
   endtask

   task automatic run_capture(input string tag, input bit arm_with_run, input bit arm_in_read,
                              input int bm, input bit post_cfg);
      int a_rd, a_dl, a_sg, guard, n;
      a_rd = cfg_rd; a_dl = cfg_dl; a_sg = cfg_sg;
      busy_mode = bm; busy_left = 0;
      sti_valid = 1'b0; run = arm_with_run; arm = 1'b1;
      tick();
      run = 1'b0;
      check({tag, "/armed"}, 64'(armed), 64'(1));
      check({tag, "/seg0"}, 64'(seg_idx), 64'(0));
      if (post_cfg) write_cfg($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 3));
      clr();
      inject_arm = arm_in_read;
      foreach (stim[i]) begin
         sti_valid = stim[i].v; sti_data = stim[i].d; run = stim[i].run; finish_now = stim[i].fin;
         tick();
      end
      sti_valid = 1'b0; run = 1'b0; finish_now = 1'b0;
      guard = 0;
      while (n_done == 0 && guard < 4000) begin
         tick();
         guard++;
      end
      repeat (4) tick();
      inject_arm = 1'b0;
      model(a_dl, a_sg);
      check({tag, "/done"}, 64'(n_done), 64'(1));
      check({tag, "/nwr"}, 64'(got_wr.size()), 64'(exp_wr.size()));
      n = (got_wr.size() < exp_wr.size()) ? got_wr.size() : exp_wr.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s/wr%0d", tag, i), 64'(got_wr[i]), 64'(exp_wr[i]));
      check({tag, "/marker"}, 64'(n_marker), 64'(exp_marker));
      check({tag, "/nrd"}, 64'(n_rd), 64'(a_rd + 1));
      check({tag, "/nsend"}, 64'(n_send), 64'(a_rd + 1));
      check({tag, "/rdwr"}, 64'(n_clash), 64'(0));
      check({tag, "/armlast"}, 64'(armed_at_last), 64'(0));
      check({tag, "/segmax"}, 64'(seg_max), 64'(exp_seg));
      check({tag, "/segsteps"}, 64'(seg_steps), 64'(exp_seg));
      check({tag, "/idle"}, 64'(armed), 64'(0));
      if (bm == 1) begin
         check({tag, "/rdbusy"}, 64'(n_rd_busy), 64'(0));
         for (int i = 1; i < send_cyc.size(); i++)
            check($sformatf("%s/gap%0d", tag, i), 64'((send_cyc[i] - send_cyc[i-1]) >= 22), 64'(1));
      end
      busy_mode = 0; out_busy = 1'b0;
   endtask

   task automatic async_reset(input string tag);
      #3 sys_rst = 1'b1;
      #1;
      check({tag, "/outs0"}, 64'({mem_wr, mem_last, mem_rd, out_send, done, armed, seg_idx, mem_wr_data}), 64'(0));
      busy_mode = 0; out_busy = 1'b0; inject_arm = 1'b0;
      arm = 1'b0; run = 1'b0; finish_now = 1'b0; sti_valid = 1'b0;
      @(negedge sys_clk);
      @(negedge sys_clk);
      sys_rst = 1'b0;
      cfg_rd = 0; cfg_dl = 0; cfg_sg = 0;
      clr();
      for (int i = 0; i < 6; i++) begin
         sti_valid = 1'(i % 2); sti_data = $urandom; run = 1'(i == 3);
         tick();
      end
      sti_valid = 1'b0; run = 1'b0;
      check({tag, "/nowr"}, 64'(got_wr.size() + n_marker), 64'(0));
      check({tag, "/nodone"}, 64'(n_done), 64'(0));
      check({tag, "/idle"}, 64'(armed), 64'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      repeat (3) @(posedge sys_clk);
      #1;
      check("reset/outs0", 64'({mem_wr, mem_last, mem_rd, out_send, done, armed, seg_idx, mem_wr_data}), 64'(0));
      @(negedge sys_clk);
      sys_rst = 1'b0;
      tick();

      // Basic single capture; a run in the arm cycle must be ignored.
      write_cfg(7, 3, 0);
      stim.delete();
      for (int i = 0; i < 10; i++) push(1'b1, DW'(i), 1'b0, 1'b0);
      push(1'b1, 'hA, 1'b1, 1'b0);
      for (int i = 11; i < 16; i++) push(1'b1, DW'(i), 1'b0, 1'b0);
      run_capture("basic", 1'b1, 1'b0, 0, 1'b0);

      // Three segments of two post-trigger samples, with extra runs afterwards.
      write_cfg(1, 1, 2);
      stim.delete();
      repeat (3) push(1'b1, $urandom, 1'b0, 1'b0);
      push(1'b1, $urandom, 1'b1, 1'b0);
      push(1'b1, $urandom, 1'b0, 1'b0);
      repeat (2) push(1'b1, $urandom, 1'b0, 1'b0);
      push(1'b0, $urandom, 1'b1, 1'b0);
      push(1'b1, $urandom, 1'b0, 1'b0);
      push(1'b0, $urandom, 1'b0, 1'b0);
      push(1'b1, $urandom, 1'b0, 1'b0);
      push(1'b1, $urandom, 1'b0, 1'b0);
      push(1'b1, $urandom, 1'b1, 1'b0);
      push(1'b1, $urandom, 1'b0, 1'b0);
      repeat (3) push(1'b1, $urandom, 1'b1, 1'b0);
      run_capture("segs", 1'b0, 1'b0, 0, 1'b0);

      // Abort in SAMPLE, then abort coinciding with run.
      write_cfg(1, 5, 0);
      stim.delete();
      repeat (3) push(1'b1, $urandom, 1'b0, 1'b0);
      push(1'b1, $urandom, 1'b0, 1'b1);
      repeat (3) push(1'b1, $urandom, 1'b0, 1'b0);
      run_capture("abort", 1'b0, 1'b0, 0, 1'b0);
      write_cfg(1, 4, 0);
      stim.delete();
      repeat (2) push(1'b1, $urandom, 1'b0, 1'b0);
      push(1'b1, $urandom, 1'b1, 1'b1);
      repeat (4) push(1'b1, $urandom, 1'b1, 1'b0);
      run_capture("abortrun", 1'b0, 1'b0, 0, 1'b0);

      // Back-pressure: busy held 20 cycles after each out_send.
      write_cfg(2, 2, 0);
      stim.delete();
      repeat (2) push(1'b1, $urandom, 1'b0, 1'b0);
      push(1'b1, $urandom, 1'b1, 1'b0);
      repeat (3) push(1'b1, $urandom, 1'b0, 1'b0);
      run_capture("bp", 1'b0, 1'b0, 1, 1'b0);

      // Gappy valid with delay 0: exactly one post-trigger write.
      write_cfg(0, 0, 0);
      stim.delete();
      for (int i = 0; i < 4; i++) push(1'(i % 2), $urandom, 1'b0, 1'b0);
      push(1'b0, $urandom, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) push(1'((i + 1) % 2), $urandom, 1'b0, 1'b0);
      run_capture("gap0", 1'b0, 1'b0, 0, 1'b0);

      // Maximum delay count.
      write_cfg(0, DMAX, 0);
      stim.delete();
      repeat (2) push(1'b1, $urandom, 1'b0, 1'b0);
      push(1'b1, $urandom, 1'b1, 1'b0);
      repeat (DMAX + 3) push(1'b1, $urandom, 1'b0, 1'b0);
      run_capture("dmax", 1'b0, 1'b0, 0, 1'b0);

      // arm while in READ has no effect.
      write_cfg(1, 1, 0);
      stim.delete();
      push(1'b1, $urandom, 1'b1, 1'b0);
      repeat (3) push(1'b1, $urandom, 1'b0, 1'b0);
      run_capture("armread", 1'b0, 1'b1, 0, 1'b0);

      // Asynchronous reset mid-DELAY.
      write_cfg(3, 50, 0);
      arm = 1'b1; tick();
      for (int i = 0; i < 3; i++) begin sti_valid = 1'b1; sti_data = $urandom; tick(); end
      run = 1'b1; tick(); run = 1'b0;
      for (int i = 0; i < 5; i++) begin sti_valid = 1'b1; sti_data = $urandom; tick(); end
      sti_valid = 1'b0;
      check("rstD/armed", 64'(armed), 64'(1));
      async_reset("rstD");

      // Asynchronous reset mid-WAIT.
      write_cfg(1, 0, 0);
      arm = 1'b1; tick();
      sti_valid = 1'b1; sti_data = $urandom; run = 1'b1; tick();
      sti_valid = 1'b0; run = 1'b0;
      busy_mode = 1; busy_left = 0;
      clr();
      guard = 0;
      while (n_send == 0 && guard < 50) begin tick(); guard++; end
      check("rstW/send", 64'(n_send), 64'(1));
      tick(); tick();
      async_reset("rstW");

      // Config registers were cleared by reset: one word, delay 0, one segment.
      stim.delete();
      repeat (2) push(1'b1, $urandom, 1'b0, 1'b0);
      push(1'b1, $urandom, 1'b1, 1'b0);
      repeat (2) push(1'b1, $urandom, 1'b0, 1'b0);
      run_capture("cfgclr", 1'b0, 1'b0, 0, 1'b0);

      // Randomized captures, including config writes while armed.
      for (int k = 0; k < 10; k++) begin
         int len;
         write_cfg($urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 3));
         stim.delete();
         len = $urandom_range(20, 60);
         for (int i = 0; i < len; i++)
            push(1'(($urandom % 4) != 0), $urandom, 1'(($urandom % 8) == 0), 1'(($urandom % 40) == 0));
         push(1'b0, '0, 1'b0, 1'b1);
         run_capture($sformatf("rnd%0d", k), 1'($urandom % 2), 1'($urandom % 2),
                     (($urandom % 2) != 0) ? 2 : 0, 1'($urandom % 2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/capture_seq.md
Name: capture_seq

Overview:
- Parametrised successor to the single-shot capture controller. It sequences arm → pre-trigger fill → post-trigger delay → readback.
- New capabilities: configurable counter widths, multi-segment (repeated-trigger) capture into one memory, and an explicit abort path.
- Sits in core between the rle_enc output stream and the memory/output-sender interface. Runs entirely in the sys_clk domain.

Parameters:
DW, 32, sample/memory data width
CW, 18, width of read and delay counters
SGW, 4, width of segment counter (max 2^SGW segments)

Ports:
sys_clk  in  1  core clock
sys_rst  in  1  asynchronous active-high reset
cfg_data  in  32  configuration word (shared command bus)
wr_read  in  1  load read_cnt = cfg_data[CW-1:0]
wr_delay  in  1  load delay_cnt = cfg_data[CW-1:0]
wr_segs  in  1  load seg_cnt = cfg_data[SGW-1:0]
arm  in  1  start capture (pulse)
run  in  1  trigger hit (pulse, already pipeline-aligned)
finish_now  in  1  abort capture, go to readback
sti_valid  in  1  sample valid
sti_data  in  DW  sample data
out_busy  in  1  output sender busy
mem_wr  out  1  memory write strobe
mem_wr_data  out  DW  memory write data
mem_last  out  1  final write of capture
mem_rd  out  1  memory read strobe
out_send  out  1  sender start pulse
seg_idx  out  SGW  current segment index
armed  out  1  high in SAMPLE/DELAY
done  out  1  one-cycle pulse when readback completes

Behaviour:
- Reset (async, sys_rst high): state=IDLE; all outputs 0. Config registers read_cnt, delay_cnt and seg_cnt clear to 0. Reset mid-operation aborts immediately; no mem_last is issued.
- Config writes are accepted in any state but take effect at the next arm. Counts are N+1 encoded:
  - read words = read_cnt+1
  - post-trigger samples per segment = delay_cnt+1
  - segments = seg_cnt+1
- States: IDLE, SAMPLE, DELAY, READ, SEND, WAIT.
- IDLE:
  - arm → SAMPLE; seg_idx=0.
  - run is ignored.
  - arm and run in the same cycle → SAMPLE; that run is ignored.
- SAMPLE:
  - Every sti_valid produces a write: mem_wr=1 and mem_wr_data=sti_data, registered, latency 1 cycle.
  - run → DELAY with delay counter=0. The run-cycle sample, if valid, counts as post-trigger sample 0.
- DELAY:
  - Each valid sample is written and increments the counter.
  - On the valid sample where counter==delay_cnt, that segment ends:
    - If seg_idx<seg_cnt: seg_idx+1, back to SAMPLE; mem_last=0.
    - Otherwise: mem_last=1 coincident with that write's mem_wr; next state READ.
  - seg_idx wraps only via re-arm; it never exceeds seg_cnt.
- finish_now in SAMPLE or DELAY:
  - Next cycle emits mem_last=1 with mem_wr=0 (marker only), then READ.
  - finish_now is ignored in all other states.
  - finish_now and run in the same cycle: finish_now wins.
- arm while not in IDLE: ignored.
- armed = (state==SAMPLE || state==DELAY).
- READ: mem_rd=1 for one cycle; read counter starts at 0 on READ entry from DELAY or abort. Next state SEND.
- SEND: out_send=1 for one cycle (memory read latency 1). Next state WAIT.
- WAIT:
  - out_busy is ignored in the first WAIT cycle; after that, wait while out_busy=1.
  - When out_busy=0: if read counter==read_cnt → IDLE with done=1 for one cycle; else increment the counter and go to READ.
- Readback cadence: minimum 4 cycles per word when out_busy is never asserted.
- No memory addressing here; the memory block owns pointers. mem_rd and mem_wr are never high together.

Test Plan:
1. Basic capture:
   - Setup: read_cnt=7, delay_cnt=3, seg_cnt=0; arm; 10 valid samples (0x0..0x9); run with sample 0xA.
   - Required: writes 0x0..0xA, 0xB, 0xC, 0xD; mem_last on 0xD; then 8 mem_rd/out_send pairs; done once; armed low after 0xD.
2. Segmented capture:
   - Setup: seg_cnt=2, delay_cnt=1; three separate run pulses.
   - Required: seg_idx steps 0→1→2; mem_last only on the second post-trigger write of segment 2; run pulses after the last segment are ignored.
3. Abort:
   - Stimulus: finish_now during SAMPLE with no run.
   - Required: next cycle mem_last=1 with mem_wr=0; READ follows.
   - Stimulus: finish_now and run asserted together.
   - Required: DELAY is never entered.
4. Back-pressure:
   - Stimulus: out_busy held high 20 cycles after each out_send, read_cnt=2.
   - Required: exactly 3 out_send pulses, each gap ≥22 cycles; no mem_rd while out_busy=1.
5. Gaps and edge values:
   - Stimulus: sti_valid toggling every other cycle in DELAY, delay_cnt=0.
   - Required: exactly one post-trigger write.
   - Stimulus: delay_cnt=2^CW-1.
   - Required: counter reaches its maximum without overflow.
6. Reset and ignored arm:
   - Stimulus: sys_rst pulse asynchronously mid-DELAY and mid-WAIT.
   - Required: outputs 0 within the reset assertion; state IDLE; no done pulse; no mem_last.
   - Stimulus: arm during READ.
   - Required: no effect.
